// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default oversampling.
// Kept in a package so the transmitter side can reuse the same constants.
package uart_receiver_pkg;

  localparam int DATA_BITS          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; 2 clk latency, no backpressure.
// Resets to 1 so an idle-high serial line never looks like a start bit out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver; byte lands in rx_data 1 clk after the stop-bit sample.
// No backpressure: an unacknowledged byte is overwritten and overrun is flagged.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e              state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [BW-1:0]          bit_idx, bit_nxt;
  logic [DATA_BITS-1:0]   shift, shift_nxt;
  logic                   commit_nxt, commit_vld;
  logic                   ferr_nxt;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      commit_vld <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      shift      <= shift_nxt;
      commit_vld <= commit_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_idx;
    shift_nxt  = shift;
    commit_nxt = 1'b0;
    ferr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_nxt   = '0;
        end
      end
      ST_START: begin
        // Re-check the line mid start bit so short glitches are dropped silently.
        if (baud_tick) begin
          if (cnt == HALF_M1) begin
            cnt_nxt   = '0;
            bit_nxt   = '0;
            state_nxt = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (cnt == FULL_M1) begin
            cnt_nxt   = '0;
            shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state_nxt = ST_STOP;
            end else begin
              bit_nxt = bit_idx + BW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (cnt == FULL_M1) begin
            cnt_nxt = '0;
            if (rx_s) begin
              commit_nxt = 1'b1;
              state_nxt  = ST_IDLE;
            end else begin
              ferr_nxt  = 1'b1;
              state_nxt = ST_BREAK;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register is stable until the next frame's data bits, so it is read one clk late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (commit_vld) begin
      rx_data  <= shift;
      rx_valid <= 1'b1;
      if (rx_valid && !rx_ack) overrun <= 1'b1;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16, baud_tick every 4 clks (64 clks per bit).
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int ferr_seen = 0;

  uart_receiver #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(posedge clk) if (frame_err) ferr_seen <= ferr_seen + 1;

  // Drives start bit and 8 data bits LSB first, then leaves rx at the stop value.
  task automatic send_body(input logic [7:0] b, input logic stop_val);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_val;
  endtask

  task automatic wait_busy_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!rx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_stop();
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h v=%b busy=%b ferr=%b ovr=%b, want all 0",
               rx_data, rx_valid, rx_busy, frame_err, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b want 0", rx_busy);
    end
  endtask

  task automatic test_good_frame();
    bit ok;
    int f0 = ferr_seen;
    send_body(8'hA5, 1'b1);
    wait_busy_low(ok);
    tests++;
    if (!ok || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL a5_stop_sample: ok=%b valid=%b want ok=1 valid=0 on stop-sample clk", ok, rx_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      fails++;
      $display("FAIL a5_commit: data=%h valid=%b want A5/1", rx_data, rx_valid);
    end
    tests++;
    if (overrun !== 1'b0 || ferr_seen != f0) begin
      fails++;
      $display("FAIL a5_flags: ovr=%b ferr_pulses=%0d want 0/0", overrun, ferr_seen - f0);
    end
    finish_stop();
  endtask

  task automatic test_ack();
    pulse_ack();
    tests++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
      fails++;
      $display("FAIL ack_clear: valid=%b data=%h want 0/A5", rx_valid, rx_data);
    end
    pulse_ack();
    tests++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL ack_idle_ignored: valid=%b ovr=%b want 0/0", rx_valid, overrun);
    end
  endtask

  task automatic test_glitch();
    int f0 = ferr_seen;
    @(negedge clk);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy: busy=%b want 1", rx_busy);
    end
    repeat (14) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    tests++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || ferr_seen != f0) begin
      fails++;
      $display("FAIL glitch_reject: busy=%b valid=%b ferr_pulses=%0d want 0/0/0",
               rx_busy, rx_valid, ferr_seen - f0);
    end
  endtask

  task automatic test_frame_error();
    bit ok = 1'b0;
    int f0 = ferr_seen;
    send_body(8'h3C, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (frame_err) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok || rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL ferr_seen: ok=%b busy=%b want 1/1", ok, rx_busy);
    end
    @(posedge clk); #1;
    tests++;
    if (frame_err !== 1'b0 || ferr_seen != f0 + 1) begin
      fails++;
      $display("FAIL ferr_one_clk: ferr=%b pulses=%0d want 0/1", frame_err, ferr_seen - f0);
    end
    repeat (90) @(negedge clk);
    tests++;
    if (rx_busy !== 1'b1 || rx_data !== 8'hA5 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL break_hold: busy=%b data=%h valid=%b want 1/A5/0", rx_busy, rx_data, rx_valid);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL break_exit: busy=%b want 0", rx_busy);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_overrun();
    bit ok;
    send_body(8'h11, 1'b1);
    wait_busy_low(ok);
    finish_stop();
    tests++;
    if (!ok || rx_data !== 8'h11 || rx_valid !== 1'b1 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL first_11: ok=%b data=%h valid=%b ovr=%b want 1/11/1/0", ok, rx_data, rx_valid, overrun);
    end
    send_body(8'h22, 1'b1);
    wait_busy_low(ok);
    finish_stop();
    tests++;
    if (!ok || rx_data !== 8'h22 || rx_valid !== 1'b1 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_22: ok=%b data=%h valid=%b ovr=%b want 1/22/1/1", ok, rx_data, rx_valid, overrun);
    end
    pulse_ack();
    tests++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_ack: valid=%b ovr=%b want 0/0", rx_valid, overrun);
    end
  endtask

  task automatic test_ack_same_edge();
    bit ok;
    send_body(8'h11, 1'b1);
    wait_busy_low(ok);
    finish_stop();
    send_body(8'h55, 1'b1);
    wait_busy_low(ok);
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    tests++;
    if (!ok || rx_data !== 8'h55 || rx_valid !== 1'b1 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL ack_on_commit: ok=%b data=%h valid=%b ovr=%b want 1/55/1/0", ok, rx_data, rx_valid, overrun);
    end
    finish_stop();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT_CLKS + 32) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({rx_data, rx_valid, rx_busy, frame_err, overrun} !== 12'h000) begin
      fails++;
      $display("FAIL midframe_reset: data=%h v=%b busy=%b ferr=%b ovr=%b want all 0",
               rx_data, rx_valid, rx_busy, frame_err, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5 * BIT_CLKS) @(negedge clk);
    tests++;
    if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL midframe_abandon: busy=%b valid=%b want 0/0", rx_busy, rx_valid);
    end
    send_body(8'h0F, 1'b1);
    wait_busy_low(ok);
    @(posedge clk); #1;
    tests++;
    if (!ok || rx_data !== 8'h0F || rx_valid !== 1'b1 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_0f: ok=%b data=%h valid=%b ovr=%b want 1/0F/1/0", ok, rx_data, rx_valid, overrun);
    end
    finish_stop();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_ack();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_ack_same_edge();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
